// File: rtl/lcd_write_engine_if.sv
// Request handshake from the sequencer plus the LCD pin bundle driven by lcd_write_engine.
// master = sequencer/observer side, slave = the engine.
interface lcd_write_engine_if;
  logic       REQ_VALID;
  logic       REQ_RS;
  logic [7:0] REQ_DATA;
  logic       REQ_READY;
  logic       DONE;
  logic [7:0] LCD_DATA_BIT;
  logic       LCD_ENABLE;
  logic       LCD_REGISTER_SELECT;
  logic       LCD_READ_WRITE;

  modport master (
    output REQ_VALID, REQ_RS, REQ_DATA,
    input  REQ_READY, DONE, LCD_DATA_BIT, LCD_ENABLE, LCD_REGISTER_SELECT, LCD_READ_WRITE
  );

  modport slave (
    input  REQ_VALID, REQ_RS, REQ_DATA,
    output REQ_READY, DONE, LCD_DATA_BIT, LCD_ENABLE, LCD_REGISTER_SELECT, LCD_READ_WRITE
  );
endinterface

// File: rtl/lcd_write_engine.sv
// Single-byte LCD write engine: accepts RS+byte on valid/ready and sequences
// setup, enable pulse, hold and settle timing on the LCD pins.
module lcd_write_engine #(
  parameter int unsigned SETUP_WAIT       = 32'd2,
  parameter int unsigned PULSE_WAIT       = 32'd12,
  parameter int unsigned HOLD_WAIT        = 32'd1,
  parameter int unsigned SETTLE_WAIT      = 32'd2000,
  parameter int unsigned LONG_SETTLE_WAIT = 32'd82000
) (
  input  logic                CLOCK_50MHZ,
  input  logic                BUTTON_SOUTH,
  lcd_write_engine_if.slave   bus
);

  // A zero wait is illegal; clamp to one cycle so the counter can never wrap.
  localparam logic [31:0] SetupLd  = (SETUP_WAIT == 0)       ? 32'd1 : 32'(SETUP_WAIT);
  localparam logic [31:0] PulseLd  = (PULSE_WAIT == 0)       ? 32'd1 : 32'(PULSE_WAIT);
  localparam logic [31:0] HoldLd   = (HOLD_WAIT == 0)        ? 32'd1 : 32'(HOLD_WAIT);
  localparam logic [31:0] SettleLd = (SETTLE_WAIT == 0)      ? 32'd1 : 32'(SETTLE_WAIT);
  localparam logic [31:0] LongLd   = (LONG_SETTLE_WAIT == 0) ? 32'd1 : 32'(LONG_SETTLE_WAIT);

  typedef enum logic [2:0] {StIdle, StSetup, StPulse, StHold, StSettle} state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  data_q, data_d;
  logic        rs_q, rs_d;
  logic        long_q, long_d;
  logic        e_q, e_d;
  logic        done_q, done_d;
  logic        cnt_last;

  assign cnt_last = (cnt_q <= 32'd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rs_d    = rs_q;
    long_d  = long_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.REQ_VALID) begin
          data_d  = bus.REQ_DATA;
          rs_d    = bus.REQ_RS;
          // Clear (0x01) and Return-Home (0x02/0x03) need the long settle.
          long_d  = !bus.REQ_RS && (bus.REQ_DATA[7:2] == 6'd0) && (bus.REQ_DATA != 8'd0);
          cnt_d   = SetupLd;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (cnt_last) begin
          cnt_d   = PulseLd;
          state_d = StPulse;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      StPulse: begin
        if (cnt_last) begin
          cnt_d   = HoldLd;
          state_d = StHold;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      StHold: begin
        if (cnt_last) begin
          cnt_d   = long_q ? LongLd : SettleLd;
          state_d = StSettle;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      StSettle: begin
        if (cnt_last) begin
          cnt_d   = 32'd0;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    e_d = (state_d == StPulse);
  end

  always_ff @(posedge CLOCK_50MHZ) begin
    if (BUTTON_SOUTH) begin
      state_q <= StIdle;
      cnt_q   <= 32'd0;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      long_q  <= 1'b0;
      e_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      long_q  <= long_d;
      e_q     <= e_d;
      done_q  <= done_d;
    end
  end

  assign bus.REQ_READY           = (state_q == StIdle);
  assign bus.DONE                = done_q;
  assign bus.LCD_DATA_BIT        = data_q;
  assign bus.LCD_REGISTER_SELECT = rs_q;
  assign bus.LCD_ENABLE          = e_q;
  assign bus.LCD_READ_WRITE      = 1'b0;

endmodule

// File: tb/tb_lcd_write_engine.sv
// Directed bench for lcd_write_engine with shortened settle waits
// (S=2, P=12, H=1, settle=20, long settle=50 -> DONE at t0+36 / t0+66).
module tb_lcd_write_engine;

  localparam int S  = 2;
  localparam int P  = 12;
  localparam int H  = 1;
  localparam int ST = 20;
  localparam int LS = 50;
  localparam int DoneNorm = 36;
  localparam int DoneLong = 66;
  localparam int Bound    = 200;

  logic clk;
  logic rst;
  int   cyc;
  int   errors;
  int   checks;

  lcd_write_engine_if bus ();

  lcd_write_engine #(
    .SETUP_WAIT      (S),
    .PULSE_WAIT      (P),
    .HOLD_WAIT       (H),
    .SETTLE_WAIT     (ST),
    .LONG_SETTLE_WAIT(LS)
  ) dut (
    .CLOCK_50MHZ (clk),
    .BUTTON_SOUTH(rst),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Pin monitor: counts E pulses and checks RS/DB stability before each rise.
  int         rises;
  int         high_cnt;
  int         last_rise;
  int         stable;
  logic       e_prev;
  logic [8:0] pins_prev;

  initial begin
    rises = 0; high_cnt = 0; last_rise = -1; stable = 0; e_prev = 1'b0; pins_prev = '0;
  end

  always @(negedge clk) begin
    if ({bus.LCD_REGISTER_SELECT, bus.LCD_DATA_BIT} == pins_prev) stable++;
    else stable = 1;
    pins_prev = {bus.LCD_REGISTER_SELECT, bus.LCD_DATA_BIT};
    if (bus.LCD_ENABLE && !e_prev) begin
      rises++;
      last_rise = cyc;
      check("rw_low", {31'd0, bus.LCD_READ_WRITE}, 32'd0);
      check("setup_stable", {31'd0, stable >= S + 1}, 32'd1);
    end
    if (bus.LCD_ENABLE) high_cnt++;
    e_prev = bus.LCD_ENABLE;
  end

  task automatic wait_ready();
    int n = 0;
    while (!bus.REQ_READY && n < Bound) begin
      tick();
      n++;
    end
    check("ready_wait", {31'd0, bus.REQ_READY}, 32'd1);
  endtask

  task automatic wait_done(input int t0, input string tag, input int exp);
    int n = 0;
    while (!bus.DONE && n < Bound) begin
      tick();
      n++;
    end
    check({tag, "_done_at"}, 32'(cyc - t0), 32'(exp));
    check({tag, "_ready_at_done"}, {31'd0, bus.REQ_READY}, 32'd1);
  endtask

  task automatic do_write(input logic rs, input logic [7:0] d, input int exp, input string tag);
    int t0, r0, h0;
    wait_ready();
    bus.REQ_VALID = 1'b1;
    bus.REQ_RS    = rs;
    bus.REQ_DATA  = d;
    t0 = cyc;
    r0 = rises;
    h0 = high_cnt;
    tick();
    bus.REQ_VALID = 1'b0;
    check({tag, "_db"}, {24'd0, bus.LCD_DATA_BIT}, {24'd0, d});
    check({tag, "_rs"}, {31'd0, bus.LCD_REGISTER_SELECT}, {31'd0, rs});
    wait_done(t0, tag, exp);
    check({tag, "_e_rise"}, 32'(last_rise - t0), 32'(1 + S));
    check({tag, "_e_len"}, 32'(high_cnt - h0), 32'(P));
    check({tag, "_e_count"}, 32'(rises - r0), 32'd1);
  endtask

  initial begin
    int t0, t1, r0, rise1;
    cyc = 0; errors = 0; checks = 0;
    rst = 1'b1;
    bus.REQ_VALID = 1'b0;
    bus.REQ_RS    = 1'b0;
    bus.REQ_DATA  = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_ready", {31'd0, bus.REQ_READY}, 32'd1);
    check("rst_e", {31'd0, bus.LCD_ENABLE}, 32'd0);
    check("rst_done", {31'd0, bus.DONE}, 32'd0);
    check("rst_db", {24'd0, bus.LCD_DATA_BIT}, 32'h00);
    check("rst_rs", {31'd0, bus.LCD_REGISTER_SELECT}, 32'd0);
    check("rst_rw", {31'd0, bus.LCD_READ_WRITE}, 32'd0);

    do_write(1'b1, 8'h44, DoneNorm, "data44");
    do_write(1'b0, 8'h01, DoneLong, "clear");
    do_write(1'b0, 8'h02, DoneLong, "home02");
    do_write(1'b0, 8'h03, DoneLong, "home03");
    do_write(1'b0, 8'h38, DoneNorm, "func38");
    do_write(1'b0, 8'h00, DoneNorm, "cmd00");
    do_write(1'b0, 8'h04, DoneNorm, "cmd04");
    do_write(1'b1, 8'h01, DoneNorm, "data01");
    check("idle_keeps_db", {24'd0, bus.LCD_DATA_BIT}, 32'h01);

    // Busy rejection: new byte presented during the enable pulse.
    wait_ready();
    bus.REQ_VALID = 1'b1; bus.REQ_RS = 1'b1; bus.REQ_DATA = 8'h44;
    t0 = cyc; r0 = rises;
    while (cyc < t0 + 5) tick();
    check("busy_in_pulse", {31'd0, bus.LCD_ENABLE}, 32'd1);
    bus.REQ_DATA = 8'h55;
    tick();
    check("busy_db", {24'd0, bus.LCD_DATA_BIT}, 32'h44);
    check("busy_ready", {31'd0, bus.REQ_READY}, 32'd0);
    while (cyc < t0 + 20) tick();
    bus.REQ_VALID = 1'b0;
    wait_done(t0, "busy", DoneNorm);
    check("busy_db_end", {24'd0, bus.LCD_DATA_BIT}, 32'h44);
    check("busy_e_count", 32'(rises - r0), 32'd1);

    // Back-to-back: valid held high across the DONE cycle.
    tick();
    wait_ready();
    bus.REQ_VALID = 1'b1; bus.REQ_RS = 1'b0; bus.REQ_DATA = 8'h18;
    t0 = cyc; r0 = rises;
    tick();
    check("b2b_db1", {24'd0, bus.LCD_DATA_BIT}, 32'h18);
    rise1 = -1;
    bus.REQ_DATA = 8'h80;
    wait_done(t0, "b2b1", DoneNorm);
    rise1 = last_rise;
    t1 = cyc;
    tick();
    bus.REQ_VALID = 1'b0;
    check("b2b_db2", {24'd0, bus.LCD_DATA_BIT}, 32'h80);
    check("b2b_busy2", {31'd0, bus.REQ_READY}, 32'd0);
    wait_done(t1, "b2b2", DoneNorm);
    check("b2b_e_count", 32'(rises - r0), 32'd2);
    check("b2b_spacing", 32'(last_rise - rise1), 32'(S + P + H + ST + 1));

    // Reset during the enable pulse.
    tick();
    wait_ready();
    bus.REQ_VALID = 1'b1; bus.REQ_RS = 1'b1; bus.REQ_DATA = 8'h44;
    t0 = cyc;
    tick();
    bus.REQ_VALID = 1'b0;
    while (cyc < t0 + 5) tick();
    check("rstp_in_pulse", {31'd0, bus.LCD_ENABLE}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstp_e", {31'd0, bus.LCD_ENABLE}, 32'd0);
    check("rstp_db", {24'd0, bus.LCD_DATA_BIT}, 32'h00);
    check("rstp_rs", {31'd0, bus.LCD_REGISTER_SELECT}, 32'd0);
    check("rstp_ready", {31'd0, bus.REQ_READY}, 32'd0 + 1);
    r0 = rises;
    begin
      int dones = 0;
      for (int i = 0; i < 60; i++) begin
        if (bus.DONE) dones++;
        tick();
      end
      check("rstp_no_done", 32'(dones), 32'd0);
    end
    check("rstp_no_e", 32'(rises - r0), 32'd0);

    // Reset and valid together: reset wins.
    bus.REQ_VALID = 1'b1; bus.REQ_RS = 1'b1; bus.REQ_DATA = 8'hAA;
    rst = 1'b1;
    r0 = rises;
    tick();
    rst = 1'b0;
    bus.REQ_VALID = 1'b0;
    check("rstv_ready", {31'd0, bus.REQ_READY}, 32'd1);
    check("rstv_db", {24'd0, bus.LCD_DATA_BIT}, 32'h00);
    for (int i = 0; i < 6; i++) tick();
    check("rstv_no_e", 32'(rises - r0), 32'd0);
    check("final_rw", {31'd0, bus.LCD_READ_WRITE}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lcd_write_engine.md
# lcd_write_engine

Low-level LCD bus driver placed directly downstream of the character/command sequencer. It accepts one byte write request at a time (register select plus 8-bit data) over a valid/ready handshake and drives the Spartan 3AN LCD pins with correct setup, enable-pulse, hold and settle timing. It returns ready only once the controller can accept the next byte. This removes all pin-level timing from the sequencer, which then only issues bytes and coarse delays.

## Interface
- SETUP_WAIT, 32'd2: cycles RS/DB are stable before E rises (tAS ≥ 40 ns at 50 MHz); must be ≥ 1
- PULSE_WAIT, 32'd12: cycles E is held high (≥ 230 ns); must be ≥ 1
- HOLD_WAIT, 32'd1: cycles RS/DB are held after E falls; must be ≥ 1
- SETTLE_WAIT, 32'd2000: settle cycles after a normal byte (≥ 40 µs); must be ≥ 1
- LONG_SETTLE_WAIT, 32'd82000: settle cycles after Clear/Return-Home (≥ 1.64 ms); must be ≥ 1
- CLOCK_50MHZ  input  1  system clock; all logic on its rising edge
- BUTTON_SOUTH  input  1  reset: one clock, synchronous, active-high
- REQ_VALID  input  1  request present; must stay stable with REQ_RS/REQ_DATA until accepted
- REQ_RS  input  1  0 = command, 1 = data (DD/CG RAM)
- REQ_DATA  input  8  byte to write
- REQ_READY  output  1  engine idle; request accepted on an edge where REQ_VALID && REQ_READY
- DONE  output  1  one-cycle pulse when a write and its settle time complete
- LCD_DATA_BIT  output  8  LCD DB[7:0]
- LCD_ENABLE  output  1  LCD E
- LCD_REGISTER_SELECT  output  1  LCD RS
- LCD_READ_WRITE  output  1  LCD R/W; constant 0 (write only)

## Operation
- FSM states: IDLE, SETUP, PULSE, HOLD, SETTLE. A 32-bit down-counter `cnt` times each state. A byte/RS latch holds the accepted request.
- IDLE: REQ_READY = 1, E = 0. On accept, latch REQ_RS/REQ_DATA, load cnt = SETUP_WAIT, go to SETUP. Also latch `long` = (REQ_RS == 0) && (REQ_DATA[7:2] == 0) && (REQ_DATA != 0), which covers 0x01 (clear) and 0x02/0x03 (home).
- SETUP: E = 0. When cnt reaches 1, load PULSE_WAIT and go to PULSE. Otherwise decrement.
- PULSE: E = 1. When cnt reaches 1, load HOLD_WAIT and go to HOLD.
- HOLD: E = 0. When cnt reaches 1, load LONG_SETTLE_WAIT if `long` else SETTLE_WAIT, and go to SETTLE.
- SETTLE: E = 0. When cnt reaches 1, go to IDLE and assert DONE for that next cycle.
- LCD_DATA_BIT and LCD_REGISTER_SELECT are driven from the latch and change only on accept. They keep the last written value while idle.
- REQ_READY = (state == IDLE), decoded from registered state. REQ_VALID while busy is ignored and not queued.
- The command byte 0x00 with RS = 0 uses the normal settle.

## Timing
- Reset values: state IDLE, cnt 0, latch 0, LCD_DATA_BIT 8'h00, LCD_REGISTER_SELECT 0, LCD_ENABLE 0, LCD_READ_WRITE 0, DONE 0, REQ_READY 1 in the first cycle after reset.
- All outputs are registered. Take the accept edge as t0:
  - RS/DB are valid from t0+1.
  - E is high for exactly PULSE_WAIT cycles, from cycle t0+1+SETUP_WAIT.
  - DONE and REQ_READY are high in cycle t0+1+SETUP_WAIT+PULSE_WAIT+HOLD_WAIT+settle.
- Back-to-back: a request held valid through the DONE cycle is accepted on that cycle's edge. The minimum accept-to-accept spacing is S+P+H+settle+1 cycles.
- Reset mid-operation, in any state: everything returns to reset values on the next edge. E drops immediately, the in-flight byte is discarded and no DONE is issued.
- Reset and REQ_VALID asserted together: reset wins and the request is not accepted.
- The counter never wraps. Parameters of 0 are illegal. An implementation may treat 0 as 1.

## Test plan
- Reset then single data write: RS=1, DATA=0x44 accepted at t0. Check DB=0x44 and RS=1 at t0+1. E is high for cycles t0+3..t0+14. DONE and REQ_READY occur at t0+2016.
- Clear command: RS=0, DATA=0x01. Check the E pulse is identical to the data write. DONE occurs at t0+82016. Repeat with 0x02 for the long settle, and with 0x38 and 0x00 for DONE at t0+2016.
- Busy rejection: change REQ_DATA to 0x55 while in PULSE with REQ_VALID=1. Check DB stays 0x44, REQ_READY=0 and there is no second E pulse.
- Back-to-back: hold REQ_VALID continuously for 0x18 then 0x80. Check the second accept happens in the DONE cycle, with exactly two E pulses 2016 cycles apart.
- Reset during PULSE: assert BUTTON_SOUTH for 1 cycle. Check E=0, DB=0x00 and RS=0 on the next edge, no DONE, and REQ_READY=1.
- Across all cases: LCD_READ_WRITE is always 0. E never rises unless RS/DB have been stable for at least SETUP_WAIT cycles. Assert this property throughout the run.
